// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver (5..MAX_DATA_WIDTH data bits,
// optional even/odd parity, 1 or 2 stop bits, break detection) feeding a
// show-ahead receive FIFO that stores each frame with its error flags.
module uart_rx_fifo #(
    parameter int MAX_WIDTH      = 32,
    parameter int MAX_DATA_WIDTH = 9,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [MAX_WIDTH-1:0]        baud_div_i,
    input  logic [3:0]                  data_bits_i,
    input  logic [1:0]                  parity_mode_i,
    input  logic                        stop_bits_i,
    input  logic                        rx_i,
    input  logic                        rx_ready_i,
    output logic [MAX_DATA_WIDTH-1:0]   rx_data_o,
    output logic                        rx_parity_error_o,
    output logic                        rx_frame_error_o,
    output logic                        rx_valid_o,
    output logic                        rx_break_o,
    output logic                        rx_overrun_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = MAX_DATA_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                sync;
    logic                      rx_prev;
    logic                      rxs, fall;
    logic [MAX_WIDTH-1:0]      tick_cnt;
    logic                      tick;
    logic [3:0]                s_cnt;
    logic                      smp7, smp8, maj;
    logic                      mid, bit_end;
    logic                      start_frame, push_req, brk_det;

    logic [3:0]                nbits;
    logic [1:0]                pmode;
    logic                      two_stop;
    logic [3:0]                bit_idx;
    logic                      stop_idx;
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      all_zero;
    logic                      par_err;
    logic                      frame_err;
    logic                      par_en, exp_par, fe_now;

    logic [ENT_W-1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      full, pop, do_push;
    logic [ENT_W-1:0]          head;

    assign rxs     = sync[1];
    assign fall    = rx_prev & ~rxs;
    // Divisors of 0 and 1 both mean one tick per clock; >= keeps the counter
    // from running away if the divisor shrinks while idle.
    assign tick    = (baud_div_i <= MAX_WIDTH'(1)) ||
                     (tick_cnt >= baud_div_i - MAX_WIDTH'(1));
    assign maj     = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);
    assign mid     = tick && (s_cnt == 4'd9);
    assign bit_end = tick && (s_cnt == 4'd15);
    assign par_en  = (pmode == 2'b01) || (pmode == 2'b10);
    assign exp_par = (^data) ^ (pmode == 2'b10);
    assign fe_now  = frame_err | ~maj;

    // Two-flop synchronizer plus previous-value flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx_i};
            rx_prev <= sync[1];
        end
    end

    // Oversample tick divider and 16-tick bit-position counter, realigned on start edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
        end else begin
            if (start_frame || tick) tick_cnt <= '0;
            else                     tick_cnt <= tick_cnt + MAX_WIDTH'(1);
            if (start_frame)
                s_cnt <= '0;
            else if (tick && state != IDLE && state != BREAK_WAIT)
                s_cnt <= s_cnt + 4'd1;
        end
    end

    // Capture the first two of the three majority-vote samples
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            smp7 <= 1'b1;
            smp8 <= 1'b1;
        end else if (tick) begin
            if (s_cnt == 4'd7) smp7 <= rxs;
            if (s_cnt == 4'd8) smp8 <= rxs;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and per-frame control strobes
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        push_req    = 1'b0;
        brk_det     = 1'b0;
        case (state)
            IDLE: if (fall) begin
                state_nxt   = START;
                start_frame = 1'b1;
            end
            START: begin
                if (mid && maj)   state_nxt = IDLE;
                else if (bit_end) state_nxt = DATA;
            end
            DATA: if (bit_end && bit_idx == nbits - 4'd1)
                state_nxt = par_en ? PARITY : STOP;
            PARITY: if (bit_end) state_nxt = STOP;
            STOP: if (mid) begin
                if (!stop_idx && all_zero && !maj) begin
                    brk_det   = 1'b1;
                    state_nxt = BREAK_WAIT;
                end else if (stop_idx == two_stop) begin
                    push_req  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BREAK_WAIT: if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath: latch format at start, assemble data and error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nbits     <= '0;
            pmode     <= '0;
            two_stop  <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            data      <= '0;
            all_zero  <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else if (start_frame) begin
            nbits     <= data_bits_i;
            pmode     <= parity_mode_i;
            two_stop  <= stop_bits_i;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            data      <= '0;
            all_zero  <= 1'b1;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else if (mid) begin
            case (state)
                DATA: begin
                    for (int i = 0; i < MAX_DATA_WIDTH; i++)
                        if (bit_idx == 4'(i)) data[i] <= maj;
                    if (maj) all_zero <= 1'b0;
                end
                PARITY: begin
                    par_err <= maj ^ exp_par;
                    if (maj) all_zero <= 1'b0;
                end
                STOP: if (!maj) frame_err <= 1'b1;
                default: ;
            endcase
        end else if (bit_end) begin
            case (state)
                DATA:    bit_idx  <= bit_idx + 4'd1;
                STOP:    stop_idx <= 1'b1;
                default: ;
            endcase
        end
    end

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = rx_valid_o && rx_ready_i;
    assign do_push = push_req && (!full || pop);

    // FIFO storage; stale entries are masked by the empty check on the outputs
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= {fe_now, par_err, data};
    end

    // FIFO pointers, occupancy and one-cycle status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rx_break_o   <= 1'b0;
            rx_overrun_o <= 1'b0;
        end else begin
            rx_break_o   <= brk_det;
            rx_overrun_o <= push_req && full && !pop;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(pop);
        end
    end

    assign head              = mem[rd_ptr];
    assign rx_valid_o        = (count != '0);
    assign fifo_count_o      = count;
    assign rx_data_o         = rx_valid_o ? head[MAX_DATA_WIDTH-1:0] : '0;
    assign rx_parity_error_o = rx_valid_o & head[MAX_DATA_WIDTH];
    assign rx_frame_error_o  = rx_valid_o & head[MAX_DATA_WIDTH+1];

endmodule
